hdmi_axi_reader: RTL and testbench

AXI4 read master sitting directly downstream of the HDMI line-prefetch address generator. Accepts one read command at a time (kick / read_addr / read_num) and splits it into AXI4 INCR bursts that never exceed MAX_BURST beats or cross a 4 KB boundary. Streams the returned 32-bit pixel words into the pixel FIFO. Reports busy back to the address generator for its command handshake.

---
 rtl/hdmi_axi_reader_if.sv | 56 +++++
 rtl/hdmi_axi_reader.sv | 139 +++++++++++++
 tb/tb_hdmi_axi_reader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_axi_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_axi_reader_if
// Description : Command, AXI4 read channel and pixel FIFO signals of the
//               HDMI AXI read master, bundled for the port list.
// Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_axi_reader_if;
    logic        kick;
    logic [31:0] read_addr;
    logic [31:0] read_num;
    logic        busy;

    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    logic        fifo_wr;
    logic [31:0] fifo_din;
    logic        fifo_full;
    logic        rd_err;

    // master: the read engine; slave: the environment around it
    modport master (
        input  kick, read_addr, read_num,
        output busy,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output fifo_wr, fifo_din,
        input  fifo_full,
        output rd_err
    );

    modport slave (
        output kick, read_addr, read_num,
        input  busy,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  fifo_wr, fifo_din,
        output fifo_full,
        input  rd_err
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_axi_reader.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_axi_reader
// Description : AXI4 read master splitting one line-prefetch command into
//               INCR bursts (<= MAX_BURST beats, no 4 KB crossing) and
//               streaming the returned words into the pixel FIFO.
//               Optional macro HDMI_AXI_RD_ERR_EN enables the rd_err monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_axi_reader #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MAX_BURST = 64
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    hdmi_axi_reader_if.master   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AR   = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [31:0] c_max_burst = 32'(MAX_BURST);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_remain;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic [8:0]  r_beat_cnt;
    logic        r_rd_err;

    logic [12:0] w_bytes_to_4k;
    logic [31:0] w_words_to_4k;
    logic [31:0] w_beats;
    logic [31:0] w_beats_m1;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_accept;
    logic        w_last_beat;

    // Addresses are word aligned, so the byte distance divides exactly by 4
    assign w_bytes_to_4k = 13'h1000 - {1'b0, r_addr[11:0]};
    assign w_words_to_4k = {21'd0, w_bytes_to_4k[12:2]};
    assign w_beats_m1    = w_beats - 32'd1;
    assign w_last_beat   = (r_beat_cnt == 9'd1);

    always_comb begin
        w_beats = r_remain;
        if (w_beats > c_max_burst)   w_beats = c_max_burst;
        if (w_beats > w_words_to_4k) w_beats = w_words_to_4k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: if (bus.kick) w_state_nxt = S_CALC;
            S_CALC: w_state_nxt = (r_remain == 32'd0) ? S_DONE : S_AR;
            S_AR: begin
                w_arvalid = 1'b1;
                if (bus.m_axi_arready) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                w_rready = !bus.fifo_full;
                w_accept = bus.m_axi_rvalid && !bus.fifo_full;
                if (w_accept && w_last_beat)
                    w_state_nxt = (r_remain == 32'd1) ? S_DONE : S_CALC;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'd0;
            r_remain   <= 32'd0;
            r_araddr   <= 32'd0;
            r_arlen    <= 8'd0;
            r_beat_cnt <= 9'd0;
        end else begin
            if (r_state == S_IDLE && bus.kick) begin
                r_addr   <= ADDR_BASE + {bus.read_addr[31:2], 2'b00};
                r_remain <= bus.read_num;
            end
            if (r_state == S_CALC && r_remain != 32'd0) begin
                r_araddr   <= r_addr;
                r_arlen    <= w_beats_m1[7:0];
                r_beat_cnt <= w_beats[8:0];
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt - 9'd1;
                r_remain   <= r_remain - 32'd1;
                r_addr     <= r_addr + 32'd4;
            end
        end
    end

`ifdef HDMI_AXI_RD_ERR_EN
    // Error response or rlast out of step with our own beat count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rd_err <= 1'b0;
        else if (w_accept && (bus.m_axi_rresp[1] || (bus.m_axi_rlast != w_last_beat)))
            r_rd_err <= 1'b1;
    end
    wire w_unused = ^{bus.read_addr[1:0], w_beats_m1[31:8], w_beats[31:9], bus.m_axi_rresp[0]};
`else
    assign r_rd_err = 1'b0;
    wire w_unused = ^{bus.read_addr[1:0], w_beats_m1[31:8], w_beats[31:9],
                      bus.m_axi_rresp, bus.m_axi_rlast};
`endif

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.m_axi_araddr  = r_araddr;
    assign bus.m_axi_arlen   = r_arlen;
    assign bus.m_axi_arsize  = 3'b010;
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arvalid = w_arvalid;
    assign bus.m_axi_rready  = w_rready;
    assign bus.fifo_wr       = w_accept;
    assign bus.fifo_din      = bus.m_axi_rdata;
    assign bus.rd_err        = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_axi_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_axi_reader
// Description : Directed bench for hdmi_axi_reader; the slave model returns
//               each beat's byte address as its data word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_axi_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hdmi_axi_reader_if bus();

    hdmi_axi_reader #(.ADDR_BASE(32'h0000_0000), .MAX_BURST(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // AXI slave model
    logic        arready_en = 1'b1;
    logic [31:0] err_addr   = 32'hFFFF_FFF0;
    logic        s_active;
    logic [31:0] s_addr;
    logic [8:0]  s_left;

    assign bus.m_axi_arready = arready_en;
    assign bus.m_axi_rvalid  = s_active;
    assign bus.m_axi_rdata   = s_addr;
    assign bus.m_axi_rlast   = s_active && (s_left == 9'd1);
    assign bus.m_axi_rresp   = (s_active && s_addr == err_addr) ? 2'b10 : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_active <= 1'b0;
            s_addr   <= 32'd0;
            s_left   <= 9'd0;
        end else if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            s_active <= 1'b1;
            s_addr   <= bus.m_axi_araddr;
            s_left   <= {1'b0, bus.m_axi_arlen} + 9'd1;
        end else if (bus.m_axi_rvalid && bus.m_axi_rready) begin
            s_addr <= s_addr + 32'd4;
            s_left <= s_left - 9'd1;
            if (s_left == 9'd1) s_active <= 1'b0;
        end
    end

    // Monitor
    logic [31:0] wr_q[$];
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];
    int busy_cyc = 0;
    int arv_cyc  = 0;
    int viol     = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.fifo_wr) wr_q.push_back(bus.fifo_din);
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                ar_addr_q.push_back(bus.m_axi_araddr);
                ar_len_q.push_back(bus.m_axi_arlen);
            end
            if (bus.busy) busy_cyc++;
            if (bus.m_axi_arvalid) arv_cyc++;
            if (bus.fifo_full && (bus.m_axi_rready || bus.fifo_wr)) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        ar_addr_q.delete();
        ar_len_q.delete();
        busy_cyc = 0;
        arv_cyc  = 0;
        viol     = 0;
    endtask

    task automatic start_cmd(input logic [31:0] addr, input logic [31:0] num);
        int n = 0;
        @(negedge clk);
        bus.kick      = 1'b1;
        bus.read_addr = addr;
        bus.read_num  = num;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.busy && n < 20);
        chk("busy_rise", bus.busy, 1);
        bus.kick = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", bus.busy, 0);
    endtask

    task automatic wait_words(input int cnt);
        int n = 0;
        while (wr_q.size() < cnt && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("words_reached", (wr_q.size() >= cnt), 1);
    endtask

    task automatic check_burst(input int idx, input logic [31:0] addr, input logic [7:0] len);
        if (idx < ar_addr_q.size()) begin
            chk("burst_addr", ar_addr_q[idx], addr);
            chk("burst_len", ar_len_q[idx], len);
        end else begin
            chk("burst_present", idx, ar_addr_q.size());
        end
    endtask

    task automatic check_words(input logic [31:0] base, input int n);
        int bad = 0;
        chk("n_words", wr_q.size(), n);
        for (int i = 0; i < wr_q.size(); i++)
            if (wr_q[i] !== base + 32'(4 * i)) bad++;
        chk("word_order", bad, 0);
    endtask

    initial begin
        bus.kick      = 1'b0;
        bus.read_addr = 32'd0;
        bus.read_num  = 32'd0;
        bus.fifo_full = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_arvalid", bus.m_axi_arvalid, 0);
        chk("rst_araddr", bus.m_axi_araddr, 32'd0);
        chk("rst_arlen", bus.m_axi_arlen, 8'd0);
        chk("rst_rready", bus.m_axi_rready, 0);
        chk("rst_fifo_wr", bus.fifo_wr, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("arsize", bus.m_axi_arsize, 3'b010);
        chk("arburst", bus.m_axi_arburst, 2'b01);
        rst_n = 1'b1;

        // 256 words from 0: four full bursts
        clear_mon();
        start_cmd(32'h0, 32'd256);
        wait_idle();
        chk("t1_nburst", ar_addr_q.size(), 4);
        for (int i = 0; i < 4; i++) check_burst(i, 32'(i * 256), 8'd63);
        check_words(32'h0, 256);

        // 4 KB boundary split
        clear_mon();
        start_cmd(32'hF80, 32'd64);
        wait_idle();
        chk("t2_nburst", ar_addr_q.size(), 2);
        check_burst(0, 32'hF80, 8'd31);
        check_burst(1, 32'h1000, 8'd31);
        check_words(32'hF80, 64);

        // Address phase stalled for 5 cycles
        clear_mon();
        arready_en = 1'b0;
        start_cmd(32'h5000, 32'd16);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t3_arvalid", bus.m_axi_arvalid, 1);
            chk("t3_araddr", bus.m_axi_araddr, 32'h5000);
            chk("t3_arlen", bus.m_axi_arlen, 8'd15);
            @(negedge clk);
        end
        arready_en = 1'b1;
        wait_idle();
        chk("t3_nburst", ar_addr_q.size(), 1);
        chk("t3_arv_cyc", arv_cyc, 6);
        check_words(32'h5000, 16);

        // FIFO full for 10 cycles mid-burst
        clear_mon();
        start_cmd(32'h2000, 32'd64);
        wait_words(10);
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_rready", bus.m_axi_rready, 0);
            chk("t4_fifo_wr", bus.fifo_wr, 0);
        end
        bus.fifo_full = 1'b0;
        wait_idle();
        chk("t4_viol", viol, 0);
        check_words(32'h2000, 64);

        // Zero-length command
        clear_mon();
        start_cmd(32'h4000, 32'd0);
        wait_idle();
        chk("t5_busy_cyc", busy_cyc, 2);
        chk("t5_arv_cyc", arv_cyc, 0);
        chk("t5_nwords", wr_q.size(), 0);

        // Reset mid-burst, then a normal command
        clear_mon();
        start_cmd(32'h6000, 32'd64);
        wait_words(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {bus.busy, bus.m_axi_arvalid, bus.m_axi_rready, bus.fifo_wr, bus.rd_err}, 0);
        chk("t6_rst_araddr", bus.m_axi_araddr, 32'd0);
        chk("t6_rst_arlen", bus.m_axi_arlen, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        start_cmd(32'h3000, 32'd64);
        wait_idle();
        chk("t6_nburst", ar_addr_q.size(), 1);
        check_burst(0, 32'h3000, 8'd63);
        check_words(32'h3000, 64);

`ifdef HDMI_AXI_RD_ERR_EN
        clear_mon();
        err_addr = 32'h7010;
        start_cmd(32'h7000, 32'd32);
        wait_idle();
        chk("rd_err_set", bus.rd_err, 1);
        check_words(32'h7000, 32);
        err_addr = 32'hFFFF_FFF0;
        clear_mon();
        start_cmd(32'h7100, 32'd16);
        wait_idle();
        chk("rd_err_sticky", bus.rd_err, 1);
`else
        chk("rd_err_tied", bus.rd_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
